// File: rtl/adder_sequencer_if.sv
// Operand/result bus between the sequencer and the external 32-bit adder.
interface adder_sequencer_if;
  logic [31:0] numA;
  logic [31:0] numB;
  logic        cin_out;
  logic [31:0] sum;
  logic        cout_in;

  modport master (output numA, numB, cin_out, input sum, cout_in);
  modport slave  (input numA, numB, cin_out, output sum, cout_in);
endinterface

// File: rtl/adder_sequencer.sv
// Byte-wise operand loader for an external adder: debounced buttons drive a
// LOAD_A -> LOAD_B -> WAIT -> DONE sequence and the captured result is shown a byte at a time.
module adder_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ADD_LATENCY     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          inp,
  input  logic                cin,
  input  logic                set,
  input  logic                clear,
  input  logic [1:0]          select,
  adder_sequencer_if.master   bus,
  output logic [7:0]          out,
  output logic                cout,
  output logic [1:0]          state,
  output logic [1:0]          byte_idx,
  output logic                done
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int WCW = (ADD_LATENCY > 0) ? $clog2(ADD_LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } st_t;

  function automatic logic [31:0] put_lane(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Bit 0 tracks set, bit 1 tracks clear.
  logic [1:0]     raw;
  logic [1:0]     sync_p0;
  logic [1:0]     sync_p1;
  logic [1:0]     db;
  logic [1:0]     db_q;
  logic [DBW-1:0] db_cnt [2];
  logic           set_p;
  logic           clr_p;

  st_t            state_q;
  st_t            state_nx;
  logic [1:0]     byte_q;
  logic [31:0]    numA_q;
  logic [31:0]    numB_q;
  logic           cin_q;
  logic [31:0]    result_q;
  logic           cout_q;
  logic [WCW-1:0] wcnt_q;

  logic           wr_a;
  logic           wr_b;
  logic           cap;
  logic           restart;

  assign raw = {clear, set};

  // Stage p0/p1: two-flop synchronizer for the raw buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: flip the level only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db        <= '0;
      db_q      <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      db_q <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign set_p = db[0] & ~db_q[0];
  assign clr_p = db[1] & ~db_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD_A;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    if (clr_p) begin
      state_nx = S_LOAD_A;
    end else begin
      case (state_q)
        S_LOAD_A: if (set_p && byte_q == 2'd3) state_nx = S_LOAD_B;
        S_LOAD_B: if (set_p && byte_q == 2'd3) state_nx = S_WAIT;
        S_WAIT:   if (wcnt_q == '0)            state_nx = S_DONE;
        S_DONE:   if (set_p)                   state_nx = S_LOAD_A;
        default:                               state_nx = S_LOAD_A;
      endcase
    end
  end

  // Clear overrides every per-state action, including a same-cycle set.
  always_comb begin
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    cap     = 1'b0;
    restart = 1'b0;
    done    = (state_q == S_DONE);
    if (!clr_p) begin
      case (state_q)
        S_LOAD_A: wr_a    = set_p;
        S_LOAD_B: wr_b    = set_p;
        S_WAIT:   cap     = (wcnt_q == '0);
        S_DONE:   restart = set_p;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      numA_q   <= '0;
      numB_q   <= '0;
      byte_q   <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      wcnt_q   <= '0;
    end else if (clr_p) begin
      numA_q   <= '0;
      numB_q   <= '0;
      byte_q   <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      if (wr_a) begin
        numA_q <= put_lane(numA_q, byte_q, inp);
        byte_q <= byte_q + 2'd1;
      end
      if (wr_b) begin
        numB_q <= put_lane(numB_q, byte_q, inp);
        byte_q <= byte_q + 2'd1;
        if (byte_q == 2'd3) begin
          cin_q  <= cin;
          wcnt_q <= WCW'(ADD_LATENCY);
        end
      end
      if (state_q == S_WAIT && wcnt_q != '0) begin
        wcnt_q <= wcnt_q - 1'b1;
      end
      if (cap) begin
        result_q <= bus.sum;
        cout_q   <= bus.cout_in;
      end
      if (restart) begin
        numA_q <= '0;
        numB_q <= '0;
        byte_q <= '0;
        cin_q  <= 1'b0;
      end
    end
  end

  assign bus.numA    = numA_q;
  assign bus.numB    = numB_q;
  assign bus.cin_out = cin_q;
  assign out         = result_q[{select, 3'b000} +: 8];
  assign cout        = cout_q;
  assign state       = state_q;
  assign byte_idx    = byte_q;

endmodule

// File: doc/adder_sequencer.md
ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a button level change.
REQ-002 Parameter: ADD_LATENCY, 2, cycles the external adder needs after operands are stable before sum/cout are valid.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below.
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 inp  input  8  operand byte from switches.
REQ-007 cin  input  1  carry-in request from switch.
REQ-008 set  input  1  raw (bouncing) "write byte / restart" button.
REQ-009 clear  input  1  raw (bouncing) "abort / clear" button.
REQ-010 select  input  2  result byte select for out.
REQ-011 sum  input  32  sum from external adder.
REQ-012 cout_in  input  1  carry-out from external adder.
REQ-013 numA, numB  output  32 each  operands driven to external adder.
REQ-014 cin_out  output  1  latched carry-in driven to external adder.
REQ-015 out  output  8  selected result byte.
REQ-016 cout  output  1  latched carry-out.
REQ-017 state  output  2  FSM state: LOAD_A=0, LOAD_B=1, WAIT=2, DONE=3.
REQ-018 byte_idx  output  2  next byte lane to be written.
REQ-019 done  output  1  high exactly while state==DONE.

Function
REQ-020 set and clear SHALL each pass through a 2-flop synchronizer and then a debouncer; the debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-021 A rising edge of each debounced level SHALL produce a 1-cycle pulse (set_p, clr_p); holding a button produces exactly one pulse.
REQ-022 clr_p in any state SHALL: state<=LOAD_A, numA<=0, numB<=0, byte_idx<=0, cin_out<=0, result<=0, cout<=0; clr_p wins over a simultaneous set_p.
REQ-023 LOAD_A: set_p writes inp to numA[8*byte_idx+7:8*byte_idx] and increments byte_idx; the write at byte_idx==3 wraps byte_idx to 0 and moves to LOAD_B.
REQ-024 LOAD_B: same, into numB; the write at byte_idx==3 also latches cin into cin_out, wraps byte_idx to 0, loads wait counter with ADD_LATENCY, moves to WAIT.
REQ-025 WAIT: counter decrements each cycle; in the cycle counter==0, sum->result and cout_in->cout are captured and state moves to DONE; WAIT therefore lasts ADD_LATENCY+1 cycles; ADD_LATENCY=0 is legal.
REQ-026 set_p SHALL be ignored in WAIT; numA, numB, cin_out SHALL NOT change in WAIT.
REQ-027 DONE: set_p moves to LOAD_A, zeroes numA, numB, byte_idx, cin_out; result and cout are retained until the next capture or clear.
REQ-028 out SHALL be result[8*select+7:8*select] combinationally in every state (select 0=bits 7:0 ... 3=bits 31:24).
REQ-029 Arithmetic is performed solely by the external adder; the block adds nothing, result is exactly 32 bits, overflow reported only via cout.

Reset
REQ-030 rst_n low SHALL immediately force state=LOAD_A, byte_idx=0, numA=numB=0, cin_out=0, result=0, cout=0, done=0, out=0, wait counter=0, synchronizer/debouncer flops and debounced levels=0.
REQ-031 Reset asserted in any state, including mid-WAIT, SHALL discard the operation; no capture occurs.
REQ-032 A button held through reset release SHALL produce one pulse once debounced, not zero.

Verification
REQ-033 Enter A bytes 78,56,34,12 and B bytes 11,11,11,11, cin=0, ideal adder model -> DONE after ADD_LATENCY+1 WAIT cycles; select=3 -> out=0x23, select=0 -> out=0x89, cout=0.
REQ-034 A=FFFFFFFF, B=00000001, cin=0 -> result 0, cout=1; repeat with B=0, cin=1 -> same.
REQ-035 set toggling with pulses of DEBOUNCE_CYCLES-1 cycles -> no byte written, byte_idx unchanged; one clean press held 100 cycles -> exactly one write.
REQ-036 clear after 5 bytes (state LOAD_B, byte_idx=1) -> LOAD_A, byte_idx=0, numA=numB=0; set and clear debounced in same cycle -> clear behaviour only.
REQ-037 rst_n low for 1 cycle mid-WAIT -> LOAD_A, result=0, done=0, no later capture.
REQ-038 set pressed during WAIT -> ignored; set pressed in DONE -> LOAD_A with previous out value still displayed.
